stg_mo_mp: RTL and testbench

- Parametrised memory-output pipeline stage; successor to the fixed two-port MO stage.
- Sits between MA and WB. Drives N memory ports with a req/ack handshake, supports narrow (1-word) and wide (2-word) accesses, and tolerates variable memory latency.
- Stalls upstream while a request is outstanding; flags a fault on timeout or an invalid port.

---
 rtl/stg_mo_pkg.sv | 19 +
 rtl/stg_mo_port_mux.sv | 44 ++++
 rtl/stg_mo_mp.sv | 201 ++++++++++++++++++++
 tb/tb_stg_mo_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stg_mo_pkg.sv
// Shared encodings and helpers for the memory-output stage.
// Holds the op codes, the FSM state type and the flattened-bus slice helper.
package stg_mo_pkg;

    localparam logic [1:0] MO_OP_NONE  = 2'd0;
    localparam logic [1:0] MO_OP_LOAD  = 2'd1;
    localparam logic [1:0] MO_OP_STORE = 2'd2;

    typedef enum logic {
        MO_ST_IDLE = 1'b0,
        MO_ST_WAIT = 1'b1
    } mo_state_t;

    // Bit offset of a port's slice inside a flattened per-port bus.
    function automatic int unsigned mo_slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/stg_mo_port_mux.sv
// One-hot memory port decode: fans the active request out to a single port
// and selects that port's ack and read data back.
module stg_mo_port_mux
    import stg_mo_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DATA_W = 24,
    parameter int PSEL_W = 1
) (
    input  logic                       act,
    input  logic [PSEL_W-1:0]          sel,
    input  logic                       we,
    input  logic                       wide,
    input  logic [2*DATA_W-1:0]        wdata,
    input  logic [NPORTS-1:0]          mem_ack,
    input  logic [NPORTS*2*DATA_W-1:0] mem_rdata,
    output logic [NPORTS-1:0]          mem_req,
    output logic [NPORTS-1:0]          mem_we,
    output logic [NPORTS-1:0]          mem_wide,
    output logic [NPORTS*2*DATA_W-1:0] mem_wdata,
    output logic                       ack_sel,
    output logic [2*DATA_W-1:0]        rdata_sel
);

    always_comb begin
        mem_req   = '0;
        mem_we    = '0;
        mem_wide  = '0;
        mem_wdata = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (act && (sel == PSEL_W'(p))) begin
                mem_req[p]  = 1'b1;
                mem_we[p]   = we;
                mem_wide[p] = wide;
                mem_wdata[mo_slice_lo(p, 2*DATA_W) +: 2*DATA_W] = wdata;
                ack_sel     = mem_ack[p];
                rdata_sel   = mem_rdata[mo_slice_lo(p, 2*DATA_W) +: 2*DATA_W];
            end
        end
    end

endmodule

// File: rtl/stg_mo_mp.sv
// Memory-output pipeline stage between MA and WB: drives N req/ack memory
// ports, holds upstream while a request is outstanding, faults on timeout.
module stg_mo_mp
    import stg_mo_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 15,
    parameter int PSEL_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst_n,
    input  logic                       iw_valid,
    input  logic [1:0]                 iw_op,
    input  logic                       iw_wide,
    input  logic [PSEL_W-1:0]          iw_port,
    input  logic [DATA_W-1:0]          iw_result,
    input  logic [2*DATA_W-1:0]        iw_wdata,
    input  logic                       iw_flush,
    output logic                       ow_stall,
    output logic [NPORTS-1:0]          ow_mem_req,
    output logic [NPORTS-1:0]          ow_mem_we,
    output logic [NPORTS-1:0]          ow_mem_wide,
    output logic [NPORTS*2*DATA_W-1:0] ow_mem_wdata,
    input  logic [NPORTS-1:0]          iw_mem_ack,
    input  logic [NPORTS*2*DATA_W-1:0] iw_mem_rdata,
    output logic                       ow_valid,
    output logic [DATA_W-1:0]          ow_result,
    output logic [2*DATA_W-1:0]        ow_wide_result,
    output logic                       ow_fault,
    output mo_state_t                  ow_dbg_state
);

    // Handshake: a port request is held until its ack; the ack cycle completes
    // the op, and ow_stall is high exactly while a request is unacknowledged.

    mo_state_t           state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic [1:0]          r_op;
    logic                r_wide;
    logic [PSEL_W-1:0]   r_port;
    logic [DATA_W-1:0]   r_result;
    logic [2*DATA_W-1:0] r_wdata;

    logic                is_mem_op, port_ok, act, capture;
    logic [PSEL_W-1:0]   sel;
    logic [1:0]          cur_op;
    logic                cur_wide;
    logic [DATA_W-1:0]   cur_result;
    logic [2*DATA_W-1:0] wdata_c, rdata_sel;
    logic                ack_sel;

    logic                valid_n, fault_n;
    logic [DATA_W-1:0]   res_n;
    logic [2*DATA_W-1:0] wres_n;

    assign is_mem_op = (iw_op == MO_OP_LOAD) || (iw_op == MO_OP_STORE);

    generate
        if ((1 << PSEL_W) == NPORTS) begin : g_port_full
            assign port_ok = 1'b1;
        end else begin : g_port_range
            assign port_ok = (32'(iw_port) < 32'(NPORTS));
        end
    endgenerate

    // In WAIT the request is replayed from the captured registers.
    always_comb begin
        cur_op     = iw_op;
        cur_wide   = iw_wide;
        cur_result = iw_result;
        sel        = iw_port;
        wdata_c    = iw_wide ? iw_wdata : {{DATA_W{1'b0}}, iw_result};
        act        = iw_valid && is_mem_op && port_ok;
        if (state == MO_ST_WAIT) begin
            cur_op     = r_op;
            cur_wide   = r_wide;
            cur_result = r_result;
            sel        = r_port;
            wdata_c    = r_wdata;
            act        = 1'b1;
        end
        if (!iw_rst_n || iw_flush) begin
            act = 1'b0;
        end
    end

    stg_mo_port_mux #(
        .NPORTS (NPORTS),
        .DATA_W (DATA_W),
        .PSEL_W (PSEL_W)
    ) u_port_mux (
        .act       (act),
        .sel       (sel),
        .we        (cur_op == MO_OP_STORE),
        .wide      (cur_wide),
        .wdata     (wdata_c),
        .mem_ack   (iw_mem_ack),
        .mem_rdata (iw_mem_rdata),
        .mem_req   (ow_mem_req),
        .mem_we    (ow_mem_we),
        .mem_wide  (ow_mem_wide),
        .mem_wdata (ow_mem_wdata),
        .ack_sel   (ack_sel),
        .rdata_sel (rdata_sel)
    );

    assign ow_stall     = act && !ack_sel;
    assign ow_dbg_state = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        valid_n = 1'b0;
        fault_n = 1'b0;
        res_n   = '0;
        wres_n  = '0;
        if (iw_flush) begin
            state_n = MO_ST_IDLE;
            cnt_n   = 8'd0;
        end else begin
            case (state)
                MO_ST_IDLE: begin
                    if (iw_valid) begin
                        if (!is_mem_op) begin
                            valid_n = 1'b1;
                            res_n   = iw_result;
                            wres_n  = {{DATA_W{1'b0}}, iw_result};
                        end else if (!port_ok) begin
                            valid_n = 1'b1;
                            fault_n = 1'b1;
                        end else if (!ack_sel) begin
                            state_n = MO_ST_WAIT;
                            cnt_n   = 8'd1;
                            capture = 1'b1;
                        end
                    end
                end
                MO_ST_WAIT: begin
                    if (!ack_sel) begin
                        if (cnt == 8'(TIMEOUT)) begin
                            state_n = MO_ST_IDLE;
                            cnt_n   = 8'd0;
                            valid_n = 1'b1;
                            fault_n = 1'b1;
                        end else begin
                            cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                        end
                    end else begin
                        state_n = MO_ST_IDLE;
                        cnt_n   = 8'd0;
                    end
                end
                default: state_n = MO_ST_IDLE;
            endcase
            // A selected ack only occurs for a live, in-range memory op.
            if (ack_sel) begin
                valid_n = 1'b1;
                if (cur_op == MO_OP_LOAD) begin
                    res_n  = rdata_sel[DATA_W-1:0];
                    wres_n = cur_wide ? rdata_sel : {{DATA_W{1'b0}}, rdata_sel[DATA_W-1:0]};
                end else begin
                    res_n  = cur_result;
                    wres_n = wdata_c;
                end
            end
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state          <= MO_ST_IDLE;
            cnt            <= 8'd0;
            r_op           <= MO_OP_NONE;
            r_wide         <= 1'b0;
            r_port         <= '0;
            r_result       <= '0;
            r_wdata        <= '0;
            ow_valid       <= 1'b0;
            ow_fault       <= 1'b0;
            ow_result      <= '0;
            ow_wide_result <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ow_valid       <= valid_n;
            ow_fault       <= fault_n;
            ow_result      <= res_n;
            ow_wide_result <= wres_n;
            if (capture) begin
                r_op     <= iw_op;
                r_wide   <= iw_wide;
                r_port   <= iw_port;
                r_result <= iw_result;
                r_wdata  <= wdata_c;
            end
        end
    end

endmodule

// File: tb/tb_stg_mo_mp.sv
// Directed bench for stg_mo_mp with three ports and a short timeout.
module tb_stg_mo_mp;
    import stg_mo_pkg::*;

    localparam int NP = 3;
    localparam int DW = 24;
    localparam int TO = 4;
    localparam int PW = 2;
    localparam int BW = NP*2*DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [1:0]        op = 2'd0;
    logic              wide = 1'b0;
    logic [PW-1:0]     port = '0;
    logic [DW-1:0]     result = '0;
    logic [2*DW-1:0]   wdata = '0;
    logic              flush = 1'b0;
    logic              stall;
    logic [NP-1:0]     mem_req, mem_we, mem_wide;
    logic [BW-1:0]     mem_wdata;
    logic [NP-1:0]     mem_ack = '0;
    logic [BW-1:0]     mem_rdata = '0;
    logic              out_valid;
    logic [DW-1:0]     out_result;
    logic [2*DW-1:0]   out_wide;
    logic              out_fault;
    mo_state_t         dbg_state;

    int n_pass = 0;
    int n_total = 0;

    stg_mo_mp #(.NPORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .iw_clk         (clk),
        .iw_rst_n       (rst_n),
        .iw_valid       (valid),
        .iw_op          (op),
        .iw_wide        (wide),
        .iw_port        (port),
        .iw_result      (result),
        .iw_wdata       (wdata),
        .iw_flush       (flush),
        .ow_stall       (stall),
        .ow_mem_req     (mem_req),
        .ow_mem_we      (mem_we),
        .ow_mem_wide    (mem_wide),
        .ow_mem_wdata   (mem_wdata),
        .iw_mem_ack     (mem_ack),
        .iw_mem_rdata   (mem_rdata),
        .ow_valid       (out_valid),
        .ow_result      (out_result),
        .ow_wide_result (out_wide),
        .ow_fault       (out_fault),
        .ow_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = MO_OP_NONE; wide = 1'b0; port = '0;
        result = '0; wdata = '0; flush = 1'b0; mem_ack = '0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd1;
        tick();
        n_total++;
        if ({out_valid, out_fault, out_result, out_wide} !== '0) $display("FAIL reset_out: got %b %b %h %h want 0", out_valid, out_fault, out_result, out_wide); else n_pass++;
        n_total++;
        if ({stall, mem_req, mem_we, mem_wide} !== '0 || mem_wdata !== '0) $display("FAIL reset_comb: stall=%b req=%b want 0", stall, mem_req); else n_pass++;
        n_total++;
        if (dbg_state !== MO_ST_IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_load_narrow();
        tick();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd1; wide = 1'b0;
        mem_rdata[1*48 +: 48] = 48'h000000ABCDEF; mem_ack = 3'b010;
        #1;
        n_total++;
        if (mem_req !== 3'b010 || mem_we !== 3'b000 || stall !== 1'b0) $display("FAIL load_req: req=%b we=%b stall=%b want 010 000 0", mem_req, mem_we, stall); else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_result !== 24'hABCDEF || out_wide !== 48'h000000ABCDEF || out_fault !== 1'b0) $display("FAIL load_res: v=%b r=%h w=%h want 1 abcdef 000000abcdef", out_valid, out_result, out_wide); else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL load_pulse: valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_store_wide();
        tick();
        valid = 1'b1; op = MO_OP_STORE; port = 2'd0; wide = 1'b1;
        wdata = 48'h123456789ABC; result = 24'h111111;
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3) ? 3'b001 : 3'b010;
            #1;
            n_total++;
            if (mem_req !== 3'b001 || mem_we !== 3'b001 || mem_wide !== 3'b001 || mem_wdata[47:0] !== 48'h123456789ABC) $display("FAIL store_req_%0d: req=%b we=%b wd=%h", k, mem_req, mem_we, mem_wdata[47:0]); else n_pass++;
            n_total++;
            if (stall !== (k < 3)) $display("FAIL store_stall_%0d: got %b want %b", k, stall, (k < 3)); else n_pass++;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL store_early_%0d: valid=%b want 0", k, out_valid); else n_pass++;
            tick();
        end
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_result !== 24'h111111 || out_wide !== 48'h123456789ABC) $display("FAIL store_res: v=%b r=%h w=%h want 1 111111 123456789abc", out_valid, out_result, out_wide); else n_pass++;
    endtask

    task automatic test_timeout();
        tick();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (stall !== 1'b1 || mem_req !== 3'b100) $display("FAIL to_stall_%0d: stall=%b req=%b want 1 100", k, stall, mem_req); else n_pass++;
            tick();
        end
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_result !== '0 || out_wide !== '0) $display("FAIL to_fault: v=%b f=%b r=%h want 1 1 0", out_valid, out_fault, out_result); else n_pass++;
        n_total++;
        if (dbg_state !== MO_ST_IDLE) $display("FAIL to_state: got %0d want 0", dbg_state); else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || out_fault !== 1'b0) $display("FAIL to_pulse: v=%b f=%b want 0 0", out_valid, out_fault); else n_pass++;
    endtask

    task automatic test_bad_port();
        tick();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd3; mem_ack = 3'b111;
        #1;
        n_total++;
        if (mem_req !== 3'b000 || stall !== 1'b0) $display("FAIL bad_req: req=%b stall=%b want 000 0", mem_req, stall); else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_result !== '0) $display("FAIL bad_fault: v=%b f=%b r=%h want 1 1 0", out_valid, out_fault, out_result); else n_pass++;
    endtask

    task automatic test_flush();
        tick();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd1;
        tick();
        tick();
        flush = 1'b1; mem_ack = 3'b010; mem_rdata[1*48 +: 48] = 48'h000000DEAD00;
        #1;
        n_total++;
        if (mem_req !== 3'b000 || stall !== 1'b0) $display("FAIL flush_req: req=%b stall=%b want 000 0", mem_req, stall); else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b0 || out_fault !== 1'b0 || dbg_state !== MO_ST_IDLE) $display("FAIL flush_drop: v=%b f=%b st=%0d want 0 0 0", out_valid, out_fault, dbg_state); else n_pass++;
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd0; mem_ack = 3'b001;
        mem_rdata[0 +: 48] = 48'h0000005A5A5A;
        tick();
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_result !== 24'h5A5A5A) $display("FAIL flush_next: v=%b r=%h want 1 5a5a5a", out_valid, out_result); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        tick();
        valid = 1'b1; op = MO_OP_LOAD; port = 2'd1;
        tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (stall !== 1'b0 || mem_req !== 3'b000 || out_valid !== 1'b0 || dbg_state !== MO_ST_IDLE) $display("FAIL rst_wait: stall=%b req=%b v=%b st=%0d want 0", stall, mem_req, out_valid, dbg_state); else n_pass++;
        idle_inputs();
        #2;
        rst_n = 1'b1;
        valid = 1'b1; op = MO_OP_NONE; result = 24'h000777;
        tick();
        idle_inputs();
        n_total++;
        if (out_valid !== 1'b1 || out_result !== 24'h000777 || out_wide !== 48'h000000000777 || out_fault !== 1'b0) $display("FAIL rst_none: v=%b r=%h w=%h want 1 000777", out_valid, out_result, out_wide); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]    b_op[4]   = '{MO_OP_LOAD, MO_OP_STORE, 2'd3, MO_OP_LOAD};
        logic [PW-1:0] b_port[4] = '{2'd0, 2'd2, 2'd1, 2'd1};
        logic          b_wide[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [DW-1:0] b_res[4]  = '{24'h010101, 24'h5C0FEE, 24'hC0FFEE, 24'h020202};
        logic [47:0]   b_rd[4]   = '{48'hFEDCBA987654, 48'h0, 48'h0, 48'h777777123456};
        logic [DW-1:0] e_res[4]  = '{24'h987654, 24'h5C0FEE, 24'hC0FFEE, 24'h123456};
        logic [47:0]   e_wide[4] = '{48'hFEDCBA987654, 48'h0000005C0FEE, 48'h000000C0FFEE, 48'h000000123456};
        tick();
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; op = b_op[i]; port = b_port[i]; wide = b_wide[i]; result = b_res[i];
            mem_rdata = '0;
            mem_rdata[b_port[i]*48 +: 48] = b_rd[i];
            mem_ack = '0;
            if (b_op[i] != 2'd3) mem_ack[b_port[i]] = 1'b1;
            #1;
            n_total++;
            if (stall !== 1'b0) $display("FAIL b2b_stall_%0d: got %b want 0", i, stall); else n_pass++;
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_result !== e_res[i] || out_wide !== e_wide[i]) $display("FAIL b2b_res_%0d: v=%b r=%h w=%h want 1 %h %h", i, out_valid, out_result, out_wide, e_res[i], e_wide[i]); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_narrow();
        test_store_wide();
        test_timeout();
        test_bad_port();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
